// File: rtl/instr_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_queue_pkg
//   Shared widths and entry type for the fetch-to-decode instruction queue.
//   Revision: 1.0
// ---------------------------------------------------------------------------
package instr_queue_pkg;

    localparam int PcLength    = 31;
    localparam int InstrLength = 31;
    localparam int IqDepthLog  = 4;

    localparam logic Zero  = 1'b0;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef struct packed {
        logic [PcLength:0]    pc;
        logic [InstrLength:0] instr;
    } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_queue
//   Circular FIFO of {pc, instr} pairs between the fetcher and the decoder,
//   head presented combinationally, flushed by the ROB on redirect.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int QueueDepthLog = IqDepthLog
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear_from_rob,
    input  logic                   is_valid_from_fetcher,
    input  logic [PcLength:0]      pc_from_fetcher,
    input  logic [InstrLength:0]   instr_from_fetcher,
    input  logic                   is_full_from_rob,
    input  logic                   is_full_from_rs,
    input  logic                   is_full_from_slb,
    output logic                   is_full_to_fetcher,
    output logic                   is_empty_to_dc,
    output logic [PcLength:0]      pc_to_dc,
    output logic [InstrLength:0]   instr_to_dc
);

    localparam int                     C_DEPTH = 1 << QueueDepthLog;
    localparam logic [QueueDepthLog:0] C_FULL  = {1'b1, {QueueDepthLog{1'b0}}};
    localparam logic [QueueDepthLog:0] C_EMPTY = '0;

    logic [QueueDepthLog-1:0] r_head;
    logic [QueueDepthLog-1:0] r_tail;
    logic [QueueDepthLog:0]   r_count;
    iq_entry_t                r_storage [C_DEPTH];

    logic      w_stall;
    logic      w_has_entry;
    logic      w_full;
    logic      w_pop;
    logic      w_push;
    iq_entry_t w_head_entry;

    assign w_stall     = is_full_from_rob | is_full_from_rs | is_full_from_slb;
    assign w_has_entry = (r_count != C_EMPTY);
    assign w_full      = (r_count == C_FULL);
    assign w_pop       = rdy & ~clear_from_rob & w_has_entry & ~w_stall;
    // Fullness is judged on the current count, so a same-cycle pop never frees a slot early.
    assign w_push      = rdy & ~clear_from_rob & is_valid_from_fetcher & ~w_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (clear_from_rob) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_storage[r_tail] <= '{pc: pc_from_fetcher, instr: instr_from_fetcher};
        end
    end

    // A stalled head must look empty so the decoder issues nothing this cycle.
    assign w_head_entry       = r_storage[r_head];
    assign is_full_to_fetcher = w_full;
    assign is_empty_to_dc     = ~w_has_entry | w_stall;
    assign pc_to_dc           = w_has_entry ? w_head_entry.pc    : '0;
    assign instr_to_dc        = w_has_entry ? w_head_entry.instr : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_queue
//   Scoreboard bench: directed scenarios plus random traffic against a
//   queue-based reference model of the instruction queue.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instr_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear_from_rob = 1'b0;
    logic        is_valid_from_fetcher = 1'b0;
    logic [31:0] pc_from_fetcher = '0;
    logic [31:0] instr_from_fetcher = '0;
    logic        is_full_from_rob = 1'b0;
    logic        is_full_from_rs = 1'b0;
    logic        is_full_from_slb = 1'b0;
    logic        is_full_to_fetcher;
    logic        is_empty_to_dc;
    logic [31:0] pc_to_dc;
    logic [31:0] instr_to_dc;

    instr_queue dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .clear_from_rob        (clear_from_rob),
        .is_valid_from_fetcher (is_valid_from_fetcher),
        .pc_from_fetcher       (pc_from_fetcher),
        .instr_from_fetcher    (instr_from_fetcher),
        .is_full_from_rob      (is_full_from_rob),
        .is_full_from_rs       (is_full_from_rs),
        .is_full_from_slb      (is_full_from_slb),
        .is_full_to_fetcher    (is_full_to_fetcher),
        .is_empty_to_dc        (is_empty_to_dc),
        .pc_to_dc              (pc_to_dc),
        .instr_to_dc           (instr_to_dc)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model and monitor: checks the presented state, then applies
    // the rules of the upcoming edge to the expected-content queue.
    always @(negedge clk) begin
        logic stall;
        logic do_pop;
        logic do_push;
        stall = is_full_from_rob | is_full_from_rs | is_full_from_slb;
        if (!rst) exp_q.delete();
        chk("is_empty_to_dc", 64'(is_empty_to_dc), 64'((exp_q.size() == 0) || stall));
        chk("is_full_to_fetcher", 64'(is_full_to_fetcher), 64'(exp_q.size() == DEPTH));
        if (exp_q.size() != 0) begin
            chk("head_pc", 64'(pc_to_dc), 64'(exp_q[0][63:32]));
            chk("head_instr", 64'(instr_to_dc), 64'(exp_q[0][31:0]));
        end else begin
            chk("empty_pc", 64'(pc_to_dc), 64'd0);
            chk("empty_instr", 64'(instr_to_dc), 64'd0);
        end
        if (rst && rdy) begin
            if (clear_from_rob) begin
                exp_q.delete();
            end else begin
                do_pop  = (exp_q.size() != 0) && !stall;
                do_push = is_valid_from_fetcher && (exp_q.size() < DEPTH);
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back({pc_from_fetcher, instr_from_fetcher});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic rob, input logic clr, input logic r);
        is_valid_from_fetcher = v;
        pc_from_fetcher       = pc;
        instr_from_fetcher    = ins;
        is_full_from_rob      = rob;
        is_full_from_rs       = 1'b0;
        is_full_from_slb      = 1'b0;
        clear_from_rob        = clr;
        rdy                   = r;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (n) step();
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, base + 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b1);
            step();
        end
    endtask

    initial begin
        int  tries;
        logic acc;

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Single push, then pop on the following edge.
        set_in(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b1);
        step();
        idle(3);

        // Fill to full under stall, reject the 17th, then re-present it.
        fill(16, 32'h0);
        set_in(1'b1, 32'h40, 32'h11111111, 1'b1, 1'b0, 1'b1);
        step();
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            set_in(1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            acc = !is_full_to_fetcher;
            tries++;
            step();
        end
        chk("refetch_accept_tries", 64'(tries), 64'd2);
        idle(20);

        // Flush together with a push.
        fill(10, 32'h100);
        set_in(1'b1, 32'h200, 32'hdeadbeef, 1'b0, 1'b1, 1'b1);
        step();
        idle(3);

        // Full with push+pop, drain to 8, then steady push+pop through wrap.
        fill(16, 32'h300);
        set_in(1'b1, 32'h400, 32'h22222222, 1'b0, 1'b0, 1'b1);
        step();
        idle(7);
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 32'h500 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b1);
            step();
        end
        idle(20);

        // rdy low freezes everything while push and pop would be legal.
        fill(4, 32'h600);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h700 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle(10);

        // Asynchronous reset in the middle of a burst.
        fill(5, 32'h800);
        set_in(1'b1, 32'h900, 32'h33333333, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_empty", 64'(is_empty_to_dc), 64'd1);
        chk("async_rst_full", 64'(is_full_to_fetcher), 64'd0);
        chk("async_rst_pc", 64'(pc_to_dc), 64'd0);
        chk("async_rst_instr", 64'(instr_to_dc), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            is_valid_from_fetcher = ($urandom_range(0, 99) < 60);
            pc_from_fetcher       = $urandom;
            instr_from_fetcher    = $urandom;
            is_full_from_rob      = ($urandom_range(0, 99) < 15);
            is_full_from_rs       = ($urandom_range(0, 99) < 15);
            is_full_from_slb      = ($urandom_range(0, 99) < 15);
            clear_from_rob        = ($urandom_range(0, 99) < 3);
            rdy                   = ($urandom_range(0, 99) >= 10);
            step();
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_queue.md
# instr_queue

Circular FIFO between the instruction fetcher and the decoder (`dc`). It buffers fetched `{pc, instr}` pairs and presents the head entry combinationally to `dc`. The head is released when no downstream buffer (ROB, RS, SLB) is full. A flush from the ROB on a mispredict or jump redirect empties the queue.

## Interface

Parameters:
- `QueueDepthLog`, default 4: log2 of the entry count (16 entries).

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: global ready; when low, all state is frozen (no push, pop or flush takes effect).
- `clear_from_rob`  in  1: flush request.
- `is_valid_from_fetcher`  in  1: push request.
- `pc_from_fetcher`  in  `PcLength`+1: PC of the pushed instruction.
- `instr_from_fetcher`  in  `InstrLength`+1: pushed instruction word.
- `is_full_from_rob`  in  1: ROB cannot accept an entry.
- `is_full_from_rs`  in  1: RS cannot accept an entry.
- `is_full_from_slb`  in  1: SLB cannot accept an entry.
- `is_full_to_fetcher`  out  1: `count == 2^QueueDepthLog`.
- `is_empty_to_dc`  out  1: `count == 0`, or a pop is blocked this cycle.
- `pc_to_dc`  out  `PcLength`+1: head PC; 0 when empty.
- `instr_to_dc`  out  `InstrLength`+1: head instruction; 0 when empty.

## Operation

State:
- `head`, `tail`: `QueueDepthLog` bits, wrapping naturally.
- `count`: `QueueDepthLog`+1 bits.
- Storage array of 2^QueueDepthLog entries, each `{pc, instr}`. Storage is not reset.

Definitions:
- `stall` = `is_full_from_rob | is_full_from_rs | is_full_from_slb`.
- `pop` = `rdy & ~clear_from_rob & (count != 0) & ~stall`.
- `push` = `rdy & ~clear_from_rob & is_valid_from_fetcher & (count != 2^QueueDepthLog)`.

Behaviour:
- `is_empty_to_dc` = `(count == 0) | stall`. The decoder and all its consumers treat "empty" as "nothing issued this cycle", so a stalled head must look empty to them.
- On push: write `storage[tail]`, then `tail <= tail + 1`.
- On pop: `head <= head + 1`.
- `count` changes by +1 for push only, −1 for pop only, and 0 for both or neither.
- Flush has top priority. `clear_from_rob & rdy` sets `head`, `tail` and `count` to 0, and the same-cycle push and pop are discarded.
- A push when full is rejected, even if a pop happens in the same cycle. `is_full_to_fetcher` is derived from the current `count` only.
- Push is permitted when empty. The new entry first appears at the head on the next cycle; there is no bypass.
- When `rdy` is low, all registers hold and outputs stay combinational on the held state.

## Timing

Reset (`rst` low, asynchronous):
- `head`, `tail`, `count` = 0.
- `is_empty_to_dc` = 1, `is_full_to_fetcher` = 0, `pc_to_dc` = 0, `instr_to_dc` = 0.
- Reset while traffic is in flight drops all entries immediately, without waiting for a clock edge.

Latency and handshakes:
- Push to head visibility: 1 cycle.
- Pop: the head is consumed at the edge where `pop` is true. The next entry, or the empty outputs, appear in that same cycle after the edge.
- The fetcher may hold `is_valid_from_fetcher` high. An entry counts as accepted only on an edge where `is_full_to_fetcher` was low. The fetcher must re-present a rejected entry.

Boundary conditions:
- Pointer wrap: `tail` going from 2^QueueDepthLog−1 to 0 needs no special handling.
- Flush and fetcher push in the same cycle: the push is lost. The fetcher is redirected by the ROB in the same cycle.
- Outputs depend combinationally on the `is_full_from_*` inputs (full flags → `is_empty_to_dc`). Upstream full flags must therefore be registered, so no combinational loop forms through `dc`.

## Structure

- `parameters.v` already holds `PcLength`, `InstrLength`, `Zero`, `True` and `False`.
- Add `IqDepthLog` (default 4) to `parameters.v`, so the fetcher and top-level can size against the queue.
- Single module, no sub-module. The storage is an inferred register array with one write port and one asynchronous read port; keep it inline.

## Test plan

- Reset then idle → `is_empty_to_dc`=1, `pc_to_dc`=0, `instr_to_dc`=0, `is_full_to_fetcher`=0.
- Push pc=0x0, instr=0x00500093, no stall:
  - cycle+1: head shows pc 0x0, instr 0x00500093, empty=0;
  - the following edge pops it, and empty returns to 1.
- Push 16 entries with `is_full_from_rob`=1 → `is_full_to_fetcher`=1 after the 16th, and a 17th push is rejected. Release the stall → entries emerge in order with pc 0x0..0x3C, one per cycle, and the 17th is accepted once count=15.
- Fill to 10, then raise `clear_from_rob` together with a push → next cycle count=0 and empty=1; the pushed entry never appears.
- Full queue with `stall`=0, push+pop in the same cycle → push rejected, count drops to 15. Then concurrent push+pop at count=8 → count stays 8. Run 40 entries to exercise pointer wrap → order is preserved.
- Drop `rdy` mid-stream for 3 cycles with valid push and pop conditions → no state change. Assert `rst` low mid-burst → outputs go to reset values without a clock edge.
